// File: rtl/carfield_dyn_addr_map_pkg.sv
// ============================================================================
// Module   : carfield_dyn_addr_map_pkg
// Purpose  : Shared types for the runtime-programmable address map:
//            - addr_rule_t : one {en, base, size} region rule
//            - cfg_field_e : field selector for config writes
//            - state_e     : commit FSM states
// Ports    : none (package)
// Options  : CARFIELD_DYN_ADDR_MAP_PERF_EN (used by the top, not here)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package carfield_dyn_addr_map_pkg;

    // Storage width of the rule fields; the map's AddrWidth must not exceed it.
    localparam int unsigned MAX_ADDR_WIDTH = 64;

    typedef struct packed {
        logic                      en;
        logic [MAX_ADDR_WIDTH-1:0] base;
        logic [MAX_ADDR_WIDTH-1:0] size;
    } addr_rule_t;

    typedef enum logic [1:0] {
        CFG_BASE = 2'd0,
        CFG_SIZE = 2'd1,
        CFG_EN   = 2'd2,
        CFG_NONE = 2'd3
    } cfg_field_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        APPLY = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/carfield_dyn_addr_map_lookup.sv
// ============================================================================
// Module   : carfield_dyn_addr_map_lookup
// Purpose  : Address lookup against the active rule table. Per-region range
//            comparators feed a lowest-index-wins priority encoder; the
//            result is held in a valid/ready output register.
// Ports    : clk_i, rst_i         - clock, sync active-high reset
//            rules_i             - active rule table
//            lk_valid_i/ready_o  - request handshake, lk_addr_i address
//            lk_valid_o/ready_i  - result handshake
//            lk_hit_o, lk_idx_o  - result (idx 0 on miss)
//            miss_acc_o          - accepted-miss pulse (PERF build only)
// Options  : CARFIELD_DYN_ADDR_MAP_PERF_EN adds miss_acc_o
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module carfield_dyn_addr_map_lookup
    import carfield_dyn_addr_map_pkg::*;
#(
    parameter int unsigned NumRegions = 8,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned IdxWidth   = $clog2(NumRegions)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  addr_rule_t [NumRegions-1:0]     rules_i,
    input  logic                            lk_valid_i,
    output logic                            lk_ready_o,
    input  logic [AddrWidth-1:0]            lk_addr_i,
    output logic                            lk_valid_o,
    input  logic                            lk_ready_i,
    output logic                            lk_hit_o,
    output logic [IdxWidth-1:0]             lk_idx_o
`ifdef CARFIELD_DYN_ADDR_MAP_PERF_EN
    ,
    output logic                            miss_acc_o
`endif
);

    logic [NumRegions-1:0] w_match;
    logic                  w_hit;
    logic [IdxWidth-1:0]   w_idx;
    logic                  w_accept;
    logic                  r_valid;
    logic                  r_hit;
    logic [IdxWidth-1:0]   r_idx;

    // End address is computed one bit wider so a region ending exactly at
    // 2^AddrWidth still compares correctly.
    for (genvar g = 0; g < NumRegions; g++) begin : g_cmp
        logic [AddrWidth:0] w_end;
        assign w_end = {1'b0, rules_i[g].base[AddrWidth-1:0]}
                     + {1'b0, rules_i[g].size[AddrWidth-1:0]};
        assign w_match[g] = rules_i[g].en
                          && (lk_addr_i >= rules_i[g].base[AddrWidth-1:0])
                          && ({1'b0, lk_addr_i} < w_end);
    end

    // Scan from the top down so the lowest matching index is left standing.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int k = int'(NumRegions) - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                w_hit = 1'b1;
                w_idx = IdxWidth'(k);
            end
        end
    end

    assign lk_ready_o = !r_valid || lk_ready_i;
    assign w_accept   = lk_valid_i && lk_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_hit   <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_hit   <= w_hit;
            r_idx   <= w_idx;
        end else if (lk_ready_i) begin
            r_valid <= 1'b0;
            r_hit   <= 1'b0;
            r_idx   <= '0;
        end
    end

    assign lk_valid_o = r_valid;
    assign lk_hit_o   = r_hit;
    assign lk_idx_o   = r_idx;

`ifdef CARFIELD_DYN_ADDR_MAP_PERF_EN
    assign miss_acc_o = w_accept && !w_hit;
`endif

endmodule

`default_nettype wire

// File: rtl/carfield_dyn_addr_map.sv
// ============================================================================
// Module   : carfield_dyn_addr_map
// Purpose  : Runtime-programmable address map. Config writes land in a
//            shadow table; a commit walks every region pair (self check for
//            i==j, overlap check for j>i) and, if clean, copies the shadow
//            table to the active table in one cycle. A sticky lock freezes
//            the map. Lookups run continuously against the active table.
// Ports    : clk_i, rst_i                      - clock, sync active-high reset
//            cfg_valid_i/ready_o, cfg_idx_i,
//            cfg_field_i, cfg_wdata_i          - shadow table write
//            commit_valid_i/ready_o            - commit request
//            commit_done_o, commit_err_o       - 1-cycle commit result pulses
//            err_idx_a_o, err_idx_b_o          - offending region pair
//            lock_i, locked_o                  - sticky lock
//            lk_*                              - lookup request/result
//            miss_cnt_o                        - miss counter (PERF build)
// Options  : CARFIELD_DYN_ADDR_MAP_PERF_EN adds the 32-bit miss_cnt_o
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module carfield_dyn_addr_map
    import carfield_dyn_addr_map_pkg::*;
#(
    parameter int unsigned                NumRegions   = 8,
    parameter int unsigned                AddrWidth    = 64,
    parameter int unsigned                IdxWidth     = $clog2(NumRegions),
    parameter addr_rule_t [NumRegions-1:0] RegionRstCfg = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [IdxWidth-1:0]   cfg_idx_i,
    input  logic [1:0]            cfg_field_i,
    input  logic [AddrWidth-1:0]  cfg_wdata_i,
    input  logic                  commit_valid_i,
    output logic                  commit_ready_o,
    output logic                  commit_done_o,
    output logic                  commit_err_o,
    output logic [IdxWidth-1:0]   err_idx_a_o,
    output logic [IdxWidth-1:0]   err_idx_b_o,
    input  logic                  lock_i,
    output logic                  locked_o,
    input  logic                  lk_valid_i,
    output logic                  lk_ready_o,
    input  logic [AddrWidth-1:0]  lk_addr_i,
    output logic                  lk_valid_o,
    input  logic                  lk_ready_i,
    output logic                  lk_hit_o,
    output logic [IdxWidth-1:0]   lk_idx_o
`ifdef CARFIELD_DYN_ADDR_MAP_PERF_EN
    ,
    output logic [31:0]           miss_cnt_o
`endif
);

    localparam logic [IdxWidth-1:0] LAST_IDX = IdxWidth'(NumRegions - 1);

    state_e                      r_state;
    addr_rule_t [NumRegions-1:0] r_shadow;
    addr_rule_t [NumRegions-1:0] r_active;
    logic [IdxWidth-1:0]         r_i;
    logic [IdxWidth-1:0]         r_j;
    logic                        r_locked;
    logic                        r_done;
    logic                        r_err;
    logic [IdxWidth-1:0]         r_err_a;
    logic [IdxWidth-1:0]         r_err_b;

    // ---------------- pair checker on the shadow table ----------------
    addr_rule_t          w_rule_a;
    addr_rule_t          w_rule_b;
    logic [AddrWidth:0]  w_end_a;
    logic [AddrWidth:0]  w_end_b;
    logic                w_self_bad;
    logic                w_overlap;
    logic                w_pair_bad;

    assign w_rule_a = r_shadow[r_i];
    assign w_rule_b = r_shadow[r_j];
    assign w_end_a  = {1'b0, w_rule_a.base[AddrWidth-1:0]} + {1'b0, w_rule_a.size[AddrWidth-1:0]};
    assign w_end_b  = {1'b0, w_rule_b.base[AddrWidth-1:0]} + {1'b0, w_rule_b.size[AddrWidth-1:0]};

    // Ending exactly at 2^AddrWidth is legal; only strictly beyond is not.
    assign w_self_bad = w_rule_a.en
                      && ((w_rule_a.size[AddrWidth-1:0] == '0)
                          || (w_end_a[AddrWidth] && (w_end_a[AddrWidth-1:0] != '0)));
    assign w_overlap  = w_rule_a.en && w_rule_b.en
                      && ({1'b0, w_rule_a.base[AddrWidth-1:0]} < w_end_b)
                      && ({1'b0, w_rule_b.base[AddrWidth-1:0]} < w_end_a);
    assign w_pair_bad = (r_i == r_j) ? w_self_bad : w_overlap;

    // ---------------- commit FSM and tables ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_shadow <= RegionRstCfg;
            r_active <= RegionRstCfg;
            r_i      <= '0;
            r_j      <= '0;
            r_locked <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_err_a  <= '0;
            r_err_b  <= '0;
        end else begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_locked <= r_locked || lock_i;
            case (r_state)
                IDLE: begin
                    // Writes land before CHECK starts, so a same-cycle
                    // write and commit is validated with the new value.
                    if (cfg_valid_i && !r_locked) begin
                        case (cfg_field_e'(cfg_field_i))
                            CFG_BASE: r_shadow[cfg_idx_i].base <= MAX_ADDR_WIDTH'(cfg_wdata_i);
                            CFG_SIZE: r_shadow[cfg_idx_i].size <= MAX_ADDR_WIDTH'(cfg_wdata_i);
                            CFG_EN:   r_shadow[cfg_idx_i].en   <= cfg_wdata_i[0];
                            default:  ;
                        endcase
                    end
                    if (commit_valid_i) begin
                        if (r_locked) begin
                            r_err   <= 1'b1;
                            r_err_a <= '0;
                            r_err_b <= '0;
                        end else begin
                            r_state <= CHECK;
                            r_i     <= '0;
                            r_j     <= '0;
                        end
                    end
                end
                CHECK: begin
                    if (w_pair_bad) begin
                        r_err   <= 1'b1;
                        r_err_a <= r_i;
                        r_err_b <= r_j;
                        r_state <= IDLE;
                    end else if (r_j == LAST_IDX) begin
                        if (r_i == LAST_IDX) begin
                            r_state <= APPLY;
                        end else begin
                            r_i <= r_i + 1'b1;
                            r_j <= r_i + 1'b1;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                APPLY: begin
                    r_active <= r_shadow;
                    r_done   <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cfg_ready_o    = (r_state == IDLE);
    assign commit_ready_o = (r_state == IDLE);
    assign commit_done_o  = r_done;
    assign commit_err_o   = r_err;
    assign err_idx_a_o    = r_err_a;
    assign err_idx_b_o    = r_err_b;
    assign locked_o       = r_locked;

    // ---------------- lookup port ----------------
`ifdef CARFIELD_DYN_ADDR_MAP_PERF_EN
    logic        w_miss_acc;
    logic [31:0] r_miss_cnt;
`endif

    carfield_dyn_addr_map_lookup #(
        .NumRegions (NumRegions),
        .AddrWidth  (AddrWidth),
        .IdxWidth   (IdxWidth)
    ) u_lookup (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rules_i    (r_active),
        .lk_valid_i (lk_valid_i),
        .lk_ready_o (lk_ready_o),
        .lk_addr_i  (lk_addr_i),
        .lk_valid_o (lk_valid_o),
        .lk_ready_i (lk_ready_i),
        .lk_hit_o   (lk_hit_o),
        .lk_idx_o   (lk_idx_o)
`ifdef CARFIELD_DYN_ADDR_MAP_PERF_EN
        ,
        .miss_acc_o (w_miss_acc)
`endif
    );

`ifdef CARFIELD_DYN_ADDR_MAP_PERF_EN
    // Counter restarts with every newly applied map.
    always_ff @(posedge clk_i) begin
        if (rst_i || r_done) begin
            r_miss_cnt <= '0;
        end else if (w_miss_acc && (r_miss_cnt != '1)) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_carfield_dyn_addr_map.sv
// ============================================================================
// Module   : tb_carfield_dyn_addr_map
// Purpose  : Self-checking bench for carfield_dyn_addr_map: reset state,
//            lookup tables, commit latency, overlap/overflow/zero-size
//            rejects, same-cycle write+commit, lock, backpressure and
//            reset during a commit.
// Options  : CARFIELD_DYN_ADDR_MAP_PERF_EN enables miss counter checks
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_carfield_dyn_addr_map;
    import carfield_dyn_addr_map_pkg::*;

    localparam addr_rule_t [7:0] TB_RST_CFG =
        {{7{addr_rule_t'('0)}},
         addr_rule_t'{en: 1'b1, base: 64'h7800_0000, size: 64'h20_0000}};

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [2:0]  cfg_idx_i = '0;
    logic [1:0]  cfg_field_i = '0;
    logic [63:0] cfg_wdata_i = '0;
    logic        commit_valid_i = 1'b0;
    logic        commit_ready_o;
    logic        commit_done_o;
    logic        commit_err_o;
    logic [2:0]  err_idx_a_o;
    logic [2:0]  err_idx_b_o;
    logic        lock_i = 1'b0;
    logic        locked_o;
    logic        lk_valid_i = 1'b0;
    logic        lk_ready_o;
    logic [63:0] lk_addr_i = '0;
    logic        lk_valid_o;
    logic        lk_ready_i = 1'b1;
    logic        lk_hit_o;
    logic [2:0]  lk_idx_o;
`ifdef CARFIELD_DYN_ADDR_MAP_PERF_EN
    logic [31:0] miss_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    carfield_dyn_addr_map #(
        .NumRegions   (8),
        .AddrWidth    (64),
        .RegionRstCfg (TB_RST_CFG)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_idx_i      (cfg_idx_i),
        .cfg_field_i    (cfg_field_i),
        .cfg_wdata_i    (cfg_wdata_i),
        .commit_valid_i (commit_valid_i),
        .commit_ready_o (commit_ready_o),
        .commit_done_o  (commit_done_o),
        .commit_err_o   (commit_err_o),
        .err_idx_a_o    (err_idx_a_o),
        .err_idx_b_o    (err_idx_b_o),
        .lock_i         (lock_i),
        .locked_o       (locked_o),
        .lk_valid_i     (lk_valid_i),
        .lk_ready_o     (lk_ready_o),
        .lk_addr_i      (lk_addr_i),
        .lk_valid_o     (lk_valid_o),
        .lk_ready_i     (lk_ready_i),
        .lk_hit_o       (lk_hit_o),
        .lk_idx_o       (lk_idx_o)
`ifdef CARFIELD_DYN_ADDR_MAP_PERF_EN
        ,
        .miss_cnt_o     (miss_cnt_o)
`endif
    );

    typedef struct {
        logic [63:0] addr;
        logic        hit;
        logic [2:0]  idx;
    } lk_vec_t;

    lk_vec_t tab_rst [4];
    lk_vec_t tab_miss[5];
    lk_vec_t tab_hit [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cfg_wr(input logic [2:0] idx, input logic [1:0] fld, input logic [63:0] d);
        cfg_valid_i = 1'b1;
        cfg_idx_i   = idx;
        cfg_field_i = fld;
        cfg_wdata_i = d;
        @(posedge clk);
        #1 cfg_valid_i = 1'b0;
    endtask

    // Cycles counted from the accept edge to the edge that shows a result.
    task automatic do_commit(output int cyc);
        commit_valid_i = 1'b1;
        @(posedge clk);
        #1 commit_valid_i = 1'b0;
        cfg_valid_i = 1'b0;
        cyc = 0;
        while (!commit_done_o && !commit_err_o && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic lookup(input string nm, input lk_vec_t v);
        lk_valid_i = 1'b1;
        lk_ready_i = 1'b1;
        lk_addr_i  = v.addr;
        @(posedge clk);
        #1 lk_valid_i = 1'b0;
        chk({nm, "_valid"}, 64'(lk_valid_o), 64'd1);
        chk({nm, "_hit"},   64'(lk_hit_o),   64'(v.hit));
        chk({nm, "_idx"},   64'(lk_idx_o),   64'(v.idx));
    endtask

    task automatic expect_err(input string nm, input int cyc, input int exp_cyc,
                              input logic [2:0] a, input logic [2:0] b);
        chk({nm, "_cyc"}, 64'(cyc), 64'(exp_cyc));
        chk({nm, "_err"}, 64'(commit_err_o), 64'd1);
        chk({nm, "_a"},   64'(err_idx_a_o), 64'(a));
        chk({nm, "_b"},   64'(err_idx_b_o), 64'(b));
    endtask

    initial begin
        int cyc;
        logic seen;

        tab_rst[0] = '{64'h7800_0010, 1'b1, 3'd0};
        tab_rst[1] = '{64'h781F_FFFF, 1'b1, 3'd0};
        tab_rst[2] = '{64'h7820_0000, 1'b0, 3'd0};
        tab_rst[3] = '{64'h77FF_FFFF, 1'b0, 3'd0};
        tab_miss[0] = '{64'h5080_0000, 1'b0, 3'd0};
        tab_miss[1] = '{64'h0000_0000, 1'b0, 3'd0};
        tab_miss[2] = '{64'h4FFF_FFFF, 1'b0, 3'd0};
        tab_miss[3] = '{64'h7820_0000, 1'b0, 3'd0};
        tab_miss[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0};
        tab_hit[0] = '{64'h507F_FFFF, 1'b1, 3'd2};
        tab_hit[1] = '{64'h5000_0000, 1'b1, 3'd2};
        tab_hit[2] = '{64'h7800_0010, 1'b1, 3'd0};
        tab_hit[3] = '{64'h5040_0000, 1'b1, 3'd2};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        chk("rst_cfg_ready",    64'(cfg_ready_o),    64'd1);
        chk("rst_commit_ready", 64'(commit_ready_o), 64'd1);
        chk("rst_lk_ready",     64'(lk_ready_o),     64'd1);
        chk("rst_outs", {56'd0, lk_valid_o, lk_hit_o, commit_done_o, commit_err_o,
                         locked_o, (err_idx_a_o | err_idx_b_o | lk_idx_o) != 3'd0, 2'd0}, 64'd0);

        for (int i = 0; i < 4; i++) lookup($sformatf("rst_tab%0d", i), tab_rst[i]);

        // ---- region 2, successful commit ----
        cfg_wr(3'd2, 2'd0, 64'h5000_0000);
        cfg_wr(3'd2, 2'd1, 64'h80_0000);
        cfg_wr(3'd2, 2'd2, 64'd1);
        do_commit(cyc);
        chk("c2_cyc",  64'(cyc), 64'd37);
        chk("c2_done", 64'(commit_done_o), 64'd1);
        @(posedge clk);
        #1 chk("c2_done_pulse", 64'(commit_done_o), 64'd0);

        for (int i = 0; i < 5; i++) lookup($sformatf("miss_tab%0d", i), tab_miss[i]);
`ifdef CARFIELD_DYN_ADDR_MAP_PERF_EN
        chk("perf_cnt5", 64'(miss_cnt_o), 64'd5);
`endif

        // ---- region 3 overlaps region 2 ----
        cfg_wr(3'd3, 2'd0, 64'h5040_0000);
        cfg_wr(3'd3, 2'd1, 64'h1000);
        cfg_wr(3'd3, 2'd2, 64'd1);
        do_commit(cyc);
        expect_err("c3", cyc, 17, 3'd2, 3'd3);
        for (int i = 0; i < 4; i++) lookup($sformatf("hit_tab%0d", i), tab_hit[i]);
        cfg_wr(3'd3, 2'd2, 64'd0);

        // ---- region 4 runs past 2^64 ----
        cfg_wr(3'd4, 2'd0, 64'hFFFF_FFFF_FFFF_F000);
        cfg_wr(3'd4, 2'd1, 64'h2000);
        cfg_wr(3'd4, 2'd2, 64'd1);
        do_commit(cyc);
        expect_err("c4", cyc, 27, 3'd4, 3'd4);
        cfg_wr(3'd4, 2'd2, 64'd0);

        // ---- region 5 enabled with zero size ----
        cfg_wr(3'd5, 2'd0, 64'h1000);
        cfg_wr(3'd5, 2'd2, 64'd1);
        do_commit(cyc);
        expect_err("c5", cyc, 31, 3'd5, 3'd5);
        cfg_wr(3'd5, 2'd2, 64'd0);

        // ---- same-cycle write and commit: CHECK must see region 6 enabled ----
        cfg_valid_i = 1'b1;
        cfg_idx_i   = 3'd6;
        cfg_field_i = 2'd2;
        cfg_wdata_i = 64'd1;
        do_commit(cyc);
        expect_err("c6", cyc, 34, 3'd6, 3'd6);
        cfg_wr(3'd6, 2'd2, 64'd0);

        // ---- clean commit again ----
        do_commit(cyc);
        chk("c7_cyc",  64'(cyc), 64'd37);
        chk("c7_done", 64'(commit_done_o), 64'd1);
        @(posedge clk);
`ifdef CARFIELD_DYN_ADDR_MAP_PERF_EN
        #1 chk("perf_cleared", 64'(miss_cnt_o), 64'd0);
`else
        #1;
`endif

        // ---- backpressure ----
        lk_ready_i = 1'b0;
        lk_valid_i = 1'b1;
        lk_addr_i  = 64'h7800_0010;
        @(posedge clk);
        #1 lk_addr_i = 64'h5000_0000;
        chk("bp_valid", 64'(lk_valid_o), 64'd1);
        chk("bp_ready", 64'(lk_ready_o), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 chk($sformatf("bp_hold%0d", k),
                   {59'd0, lk_valid_o, lk_hit_o, lk_idx_o}, {59'd0, 1'b1, 1'b1, 3'd0});
            chk($sformatf("bp_rdy%0d", k), 64'(lk_ready_o), 64'd0);
        end
        lk_ready_i = 1'b1;
        #1 chk("bp_ready_back", 64'(lk_ready_o), 64'd1);
        @(posedge clk);
        #1 chk("bp_next", {59'd0, lk_valid_o, lk_hit_o, lk_idx_o}, {59'd0, 1'b1, 1'b1, 3'd2});
        lk_valid_i = 1'b0;
        @(posedge clk);
        #1 chk("bp_drain", 64'(lk_valid_o), 64'd0);

        // ---- lock ----
        lock_i = 1'b1;
        @(posedge clk);
        #1 lock_i = 1'b0;
        chk("lock_set", 64'(locked_o), 64'd1);
        chk("lock_cfg_ready", 64'(cfg_ready_o), 64'd1);
        cfg_wr(3'd5, 2'd0, 64'h6000_0000);
        cfg_wr(3'd5, 2'd1, 64'h100);
        cfg_wr(3'd5, 2'd2, 64'd1);
        do_commit(cyc);
        expect_err("lk", cyc, 0, 3'd0, 3'd0);
        @(posedge clk);
        #1 chk("lk_err_pulse", 64'(commit_err_o), 64'd0);
        chk("lk_sticky", 64'(locked_o), 64'd1);
        lookup("lk_miss", '{64'h6000_0000, 1'b0, 3'd0});
        lookup("lk_old",  '{64'h5000_0000, 1'b1, 3'd2});

        // ---- reset during a commit ----
        rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        chk("rst2_unlock", 64'(locked_o), 64'd0);
        commit_valid_i = 1'b1;
        @(posedge clk);
        #1 commit_valid_i = 1'b0;
        chk("mid_busy", 64'(commit_ready_o), 64'd0);
        repeat (5) @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1 seen = seen | commit_done_o | commit_err_o;
        end
        chk("mid_no_pulse", 64'(seen), 64'd0);
        chk("mid_idle", 64'(commit_ready_o), 64'd1);
        lookup("mid_rstmap", '{64'h5000_0000, 1'b0, 3'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
